iodev_fifo_port: RTL and testbench
==================================

Name: iodev_fifo_port

Overview:
- Downstream I/O peripheral on the CFT backplane. It consumes I/O-space bus transactions (nio/nr/nw, ab[7:0], db) inside the niodev1xx page.
- It buffers words written by the processor into a FIFO and presents them to a local consumer over a valid/ready stream.
- It holds the processor off with wait states (nWS) when the FIFO is full, and raises an open-drain interrupt request when the FIFO level falls to a programmable threshold.

Parameters:
- BASE_ADDR, 8'h10, I/O offset of register block within the niodev1xx page; bits [1:0] ignored.
- DEPTH_LOG2, 4, log2 of FIFO depth (16 words).

Ports:
- clk1  in  1  bus phase clock; only clock.
- reset  in  1  synchronous, active-high reset.
- niodev  in  1  decoded page select (niodev1xx), active low.
- nio  in  1  I/O transaction, active low.
- nr  in  1  read strobe, active low.
- nw  in  1  write strobe, active low.
- ab_lo  in  8  ab[7:0].
- db_in  in  16  data bus, sampled on write.
- db_out  out  16  read data.
- db_oe  out  1  drive db_out onto db.
- nws_drv  out  1  1 = pull nWS low (insert wait state).
- irq_drv  out  1  1 = pull assigned nIRQn line low.
- out_data  out  16  FIFO head word.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.

Behaviour:
- sel = !niodev & !nio & (ab_lo[7:2] == BASE_ADDR[7:2]). Register index is ab_lo[1:0]: 0 DATA, 1 STATUS, 2 CTRL, 3 THRESH.
- nw_q is a registered copy of nw. The write event fires for one cycle when sel & !nw & nw_q. Repeated cycles of the same strobe never re-fire.
- Reads: db_oe = sel & !nr (combinational).
  - db_out for DATA = 16'h0000.
  - STATUS = {3'b0, count[4:0], 4'b0, stalled, irq_drv, full, empty}.
  - CTRL = {14'b0, 1'b0, irq_en}.
  - THRESH = {11'b0, thresh[4:0]}.
  - count is DEPTH_LOG2+1 bits wide.
- DATA write:
  - If !full, or pop occurs in the same cycle, push db_in at the clock edge.
  - If full with no pop: latch db_in into a pending register, set stalled, and assert nws_drv from the next cycle.
  - While stalled, the first pop cycle pushes the pending word (count unchanged). stalled and nws_drv clear on the following edge.
- Pop = out_valid & out_ready. out_data is the head word, valid the same cycle as out_valid.
- Simultaneous push and pop: count unchanged, both take effect. Pointers wrap modulo 2^DEPTH_LOG2. full = (count == 2^DEPTH_LOG2), empty = (count == 0).
- CTRL write:
  - bit0 sets irq_en.
  - bit1 = flush (self-clearing; not stored). Flush empties the FIFO, clears stalled and nws_drv, and discards the pending word.
  - Flush has priority over a same-cycle pop or push.
- THRESH write stores db_in[4:0]. Values above 2^DEPTH_LOG2 are saturated to 2^DEPTH_LOG2.
- irq_drv is registered: irq_drv <= irq_en & (count_next <= thresh). Level-sensitive, with no acknowledge; the processor clears it by refilling the FIFO or clearing irq_en.
- Writes to STATUS are ignored.
- Reset (synchronous) values:
  - FIFO empty, pointers 0, count 0.
  - irq_en 0, thresh 0, stalled 0.
  - nws_drv 0, irq_drv 0, out_valid 0.
  - nw_q 1.
  - Reset during a stall drops the pending word and releases nws_drv on the next edge.
- Latency: a write on edge N makes out_valid = 1 after edge N (visible in cycle N+1).

Decomposition:
- Shared package cft_iodev_pkg holds:
  - register index constants REG_DATA/REG_STATUS/REG_CTRL/REG_THRESH;
  - STATUS bit positions;
  - CTRL bit positions (CTRL_IRQEN, CTRL_FLUSH).
- One sub-module: iodev_sync_fifo (parameterised DEPTH_LOG2, width 16, push/pop/flush, count, full/empty). The top handles bus decode, stall register and IRQ.

Test Plan:
- Reset, then read STATUS -> db_out = 16'h0001 (empty). out_valid = 0, nws_drv = 0, irq_drv = 0.
- Write 16'hBEEF to DATA with out_ready = 0 -> out_valid = 1 next cycle, out_data = 16'hBEEF, STATUS = 16'h0100 (count 1). Hold nw low 5 cycles -> count stays 1.
- Write 16 words 0..15, then a 17th word 16'h0011 with out_ready = 0 -> STATUS full bit set, nws_drv = 1 and stalled = 1 from the next cycle. Pulse out_ready once -> 16'h0000 popped, the 17th word pushed, count stays 16, nws_drv = 0 one cycle later. Drain -> sequence 1..15, 16'h0011.
- THRESH = 2, CTRL = 1, fill 4 words, drain with out_ready held 1 -> irq_drv rises on the edge where count becomes 2 and stays high at 0. Write CTRL = 0 -> irq_drv = 0 next cycle.
- While stalled on a full FIFO, write CTRL = 16'h0002 -> count 0, out_valid = 0, nws_drv = 0, pending word never appears on out_data.
- Assert reset mid-stall, with out_ready = 1 and a simultaneous push/pop -> all state cleared next edge, STATUS = 16'h0001.

Source files
------------

// File: rtl/cft_iodev_pkg.sv
// Shared definitions for CFT backplane I/O peripherals: register map,
// STATUS/CTRL bit positions and the decoded write payload.
package cft_iodev_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned REG_IDX_W = 2;
    localparam int unsigned CNT_FLD_W = 5;

    typedef enum logic [REG_IDX_W-1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_idx_e;

    localparam int unsigned STAT_EMPTY     = 0;
    localparam int unsigned STAT_FULL      = 1;
    localparam int unsigned STAT_IRQ       = 2;
    localparam int unsigned STAT_STALLED   = 3;
    localparam int unsigned STAT_COUNT_LSB = 8;

    localparam int unsigned CTRL_IRQEN = 0;
    localparam int unsigned CTRL_FLUSH = 1;

    typedef struct packed {
        reg_idx_e            idx;
        logic [DATA_W-1:0]   data;
    } bus_wr_t;

    // Assemble the STATUS read word from its fields.
    function automatic logic [DATA_W-1:0] status_word(
        input logic [CNT_FLD_W-1:0] count,
        input logic                 stalled,
        input logic                 irq,
        input logic                 full,
        input logic                 empty
    );
        logic [DATA_W-1:0] w;
        w                                = '0;
        w[STAT_COUNT_LSB +: CNT_FLD_W]   = count;
        w[STAT_STALLED]                  = stalled;
        w[STAT_IRQ]                      = irq;
        w[STAT_FULL]                     = full;
        w[STAT_EMPTY]                    = empty;
        return w;
    endfunction

endpackage

// File: rtl/iodev_sync_fifo.sv
// Single-clock FIFO with occupancy count, registered full/empty and a
// flush that empties the buffer with priority over push and pop.
module iodev_sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_next_c,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_empty;

    logic                  w_pop;
    logic                  w_push;
    logic [CNT_W-1:0]      w_count_next;

    // Never underflow; only overwrite a full buffer when a slot frees this cycle.
    assign w_pop  = pop & ~r_empty & ~flush;
    assign w_push = push & (~r_full | w_pop) & ~flush;

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage is not reset; the pointers and count alone define contents.
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata        = r_mem[r_rd_ptr];
    assign count        = r_count;
    assign count_next_c = w_count_next;
    assign full         = r_full;
    assign empty        = r_empty;

endmodule

// File: rtl/iodev_fifo_port.sv
// Backplane I/O peripheral: decodes a 4-register block, buffers DATA writes
// into a FIFO streamed to a local consumer, stalls the bus when full and
// raises a level interrupt when the fill level drops to a threshold.
module iodev_fifo_port
    import cft_iodev_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR  = 8'h10,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                clk1,
    input  logic                reset,
    input  logic                niodev,
    input  logic                nio,
    input  logic                nr,
    input  logic                nw,
    input  logic [7:0]          ab_lo,
    input  logic [DATA_W-1:0]   db_in,
    output logic [DATA_W-1:0]   db_out,
    output logic                db_oe,
    output logic                nws_drv,
    output logic                irq_drv,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned TH_W  = CNT_FLD_W;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_STALL = 1'b1
    } stall_state_e;

    stall_state_e          r_state;
    stall_state_e          w_state_next;

    logic                  r_nw_q;
    logic [DATA_W-1:0]     r_pending;
    logic                  r_irq_en;
    logic [TH_W-1:0]       r_thresh;
    logic                  r_irq_drv;

    logic                  w_sel;
    logic                  w_wr;
    bus_wr_t               w_bus;
    logic                  w_wr_data;
    logic                  w_wr_ctrl;
    logic                  w_wr_thresh;
    logic                  w_flush;
    logic                  w_pop;
    logic                  w_push;
    logic [DATA_W-1:0]     w_push_data;
    logic                  w_latch_pending;
    logic                  w_irq_en_next;
    logic [TH_W-1:0]       w_th_in;

    logic [DATA_W-1:0]     w_head;
    logic [CNT_W-1:0]      w_count;
    logic [CNT_W-1:0]      w_count_next;
    logic                  w_full;
    logic                  w_empty;

    // Bus decode; a write fires only on the falling edge of the strobe.
    assign w_sel       = ~niodev & ~nio & (ab_lo[7:2] == BASE_ADDR[7:2]);
    assign w_wr        = w_sel & ~nw & r_nw_q;
    assign w_bus       = '{idx: reg_idx_e'(ab_lo[1:0]), data: db_in};
    assign w_wr_data   = w_wr & (w_bus.idx == REG_DATA);
    assign w_wr_ctrl   = w_wr & (w_bus.idx == REG_CTRL);
    assign w_wr_thresh = w_wr & (w_bus.idx == REG_THRESH);
    assign w_flush     = w_wr_ctrl & w_bus.data[CTRL_FLUSH];
    assign w_pop       = ~w_empty & out_ready;

    always_ff @(posedge clk1) begin
        if (reset) r_nw_q <= 1'b1;
        else       r_nw_q <= nw;
    end

    always_ff @(posedge clk1) begin
        if (reset) r_state <= S_RUN;
        else       r_state <= w_state_next;
    end

    // Stall control: a DATA write into a full FIFO parks the word until a pop.
    always_comb begin
        w_state_next    = r_state;
        w_push          = 1'b0;
        w_push_data     = w_bus.data;
        w_latch_pending = 1'b0;
        if (w_flush) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_wr_data) begin
                        if (!w_full || w_pop) begin
                            w_push = 1'b1;
                        end else begin
                            w_latch_pending = 1'b1;
                            w_state_next    = S_STALL;
                        end
                    end
                end
                S_STALL: begin
                    if (w_pop) begin
                        w_push       = 1'b1;
                        w_push_data  = r_pending;
                        w_state_next = S_RUN;
                    end
                end
                default: w_state_next = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk1) begin
        if (reset || w_flush) r_pending <= '0;
        else if (w_latch_pending) r_pending <= w_bus.data;
    end

    assign w_irq_en_next = w_wr_ctrl ? w_bus.data[CTRL_IRQEN] : r_irq_en;
    assign w_th_in       = w_bus.data[TH_W-1:0];

    always_ff @(posedge clk1) begin
        if (reset) begin
            r_irq_en  <= 1'b0;
            r_thresh  <= '0;
            r_irq_drv <= 1'b0;
        end else begin
            r_irq_en  <= w_irq_en_next;
            if (w_wr_thresh) begin
                if (32'(w_th_in) > DEPTH) r_thresh <= TH_W'(DEPTH);
                else                      r_thresh <= w_th_in;
            end
            r_irq_drv <= w_irq_en_next & (32'(w_count_next) <= 32'(r_thresh));
        end
    end

    iodev_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (DATA_W)
    ) u_fifo (
        .clk          (clk1),
        .reset        (reset),
        .push         (w_push),
        .pop          (w_pop),
        .flush        (w_flush),
        .wdata        (w_push_data),
        .rdata        (w_head),
        .count        (w_count),
        .count_next_c (w_count_next),
        .full         (w_full),
        .empty        (w_empty)
    );

    // Register read mux; DATA is write-only and reads back as zero.
    always_comb begin
        db_out = '0;
        case (w_bus.idx)
            REG_DATA:   db_out = '0;
            REG_STATUS: db_out = status_word(CNT_FLD_W'(w_count), (r_state == S_STALL),
                                             r_irq_drv, w_full, w_empty);
            REG_CTRL:   db_out = {15'b0, r_irq_en};
            REG_THRESH: db_out = {11'b0, r_thresh};
            default:    db_out = '0;
        endcase
    end

    assign db_oe     = w_sel & ~nr;
    assign nws_drv   = (r_state == S_STALL);
    assign irq_drv   = r_irq_drv;
    assign out_data  = w_head;
    assign out_valid = ~w_empty;

endmodule

// File: tb/tb_iodev_fifo_port.sv
// Directed bench for iodev_fifo_port: stimulus queues expected stream words,
// a negedge monitor checks every accepted head word against that queue.
module tb_iodev_fifo_port;

    localparam logic [7:0] A_DATA   = 8'h10;
    localparam logic [7:0] A_STATUS = 8'h11;
    localparam logic [7:0] A_CTRL   = 8'h12;
    localparam logic [7:0] A_THRESH = 8'h13;

    logic        clk1;
    logic        reset;
    logic        niodev, nio, nr, nw;
    logic [7:0]  ab_lo;
    logic [15:0] db_in;
    logic [15:0] db_out;
    logic        db_oe;
    logic        nws_drv;
    logic        irq_drv;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];

    iodev_fifo_port #(
        .BASE_ADDR  (8'h10),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk1      (clk1),
        .reset     (reset),
        .niodev    (niodev),
        .nio       (nio),
        .nr        (nr),
        .nw        (nw),
        .ab_lo     (ab_lo),
        .db_in     (db_in),
        .db_out    (db_out),
        .db_oe     (db_oe),
        .nws_drv   (nws_drv),
        .irq_drv   (irq_drv),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every accepted head word must match the queue front.
    always @(negedge clk1) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %h expected no data at %0t", out_data, $time);
            end else begin
                check16("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk1);
        #1;
    endtask

    task automatic bus_idle;
        niodev = 1'b1;
        nio    = 1'b1;
        nr     = 1'b1;
        nw     = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        tick;
        niodev = 1'b0;
        nio    = 1'b0;
        nw     = 1'b0;
        ab_lo  = a;
        db_in  = d;
        tick;
        bus_idle;
    endtask

    task automatic push_word(input logic [15:0] d);
        exp_q.push_back(d);
        wr(A_DATA, d);
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string name);
        niodev = 1'b0;
        nio    = 1'b0;
        nr     = 1'b0;
        ab_lo  = a;
        @(negedge clk1);
        check16(name, db_out, exp);
        bus_idle;
    endtask

    task automatic pop_n(input int n);
        tick;
        out_ready = 1'b1;
        repeat (n) tick;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic irq_exp [4];
        bus_idle;
        ab_lo     = 8'h00;
        db_in     = 16'h0000;
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) tick;
        reset = 1'b0;

        // Reset state
        rd(A_STATUS, 16'h0001, "rst_status");
        check16("rst_valid", 16'(out_valid), 16'h0);
        check16("rst_nws",   16'(nws_drv),   16'h0);
        check16("rst_irq",   16'(irq_drv),   16'h0);
        #1 check16("idle_oe", 16'(db_oe), 16'h0);

        // Single write, strobe held low for several cycles
        exp_q.push_back(16'hBEEF);
        tick;
        niodev = 1'b0; nio = 1'b0; nw = 1'b0; ab_lo = A_DATA; db_in = 16'hBEEF;
        tick;
        @(negedge clk1);
        check16("beef_valid", 16'(out_valid), 16'h1);
        check16("beef_data",  out_data,       16'hBEEF);
        repeat (5) tick;
        bus_idle;
        rd(A_STATUS, 16'h0100, "hold_count1");
        pop_n(1);
        rd(A_STATUS, 16'h0001, "beef_drained");

        // Fill to full, stall on the 17th word, release with a single pop
        for (int i = 0; i < 16; i++) push_word(16'(i));
        rd(A_STATUS, 16'h1002, "full_status");
        push_word(16'h0011);
        rd(A_STATUS, 16'h100A, "stall_status");
        check16("stall_nws", 16'(nws_drv), 16'h1);
        pop_n(1);
        rd(A_STATUS, 16'h1002, "unstall_status");
        check16("unstall_nws", 16'(nws_drv), 16'h0);
        pop_n(16);
        rd(A_STATUS, 16'h0001, "drain_status");

        // Threshold interrupt across a drain
        wr(A_THRESH, 16'h0002);
        wr(A_CTRL,   16'h0001);
        @(negedge clk1);
        check16("irq_empty", 16'(irq_drv), 16'h1);
        push_word(16'hA001);
        push_word(16'hA002);
        push_word(16'hA003);
        push_word(16'hA004);
        rd(A_STATUS, 16'h0400, "irq_fill4");
        irq_exp = '{1'b0, 1'b1, 1'b1, 1'b1};
        tick;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            @(negedge clk1);
            check16($sformatf("irq_drain%0d", i), 16'(irq_drv), 16'(irq_exp[i]));
        end
        out_ready = 1'b0;
        rd(A_STATUS, 16'h0005, "irq_status");
        rd(A_CTRL,   16'h0001, "ctrl_read");
        rd(A_THRESH, 16'h0002, "thresh_read");
        wr(A_CTRL, 16'h0000);
        @(negedge clk1);
        check16("irq_off", 16'(irq_drv), 16'h0);
        wr(A_THRESH, 16'h001F);
        rd(A_THRESH, 16'h0010, "thresh_sat");
        wr(A_THRESH, 16'hFFEF);
        rd(A_THRESH, 16'h000F, "thresh_low5");
        wr(A_STATUS, 16'hFFFF);
        rd(A_STATUS, 16'h0001, "status_ro");

        // Flush while stalled discards the pending word
        for (int i = 0; i < 16; i++) push_word(16'h0100 + 16'(i));
        wr(A_DATA, 16'hABCD);
        @(negedge clk1);
        check16("flush_pre_nws", 16'(nws_drv), 16'h1);
        wr(A_CTRL, 16'h0002);
        exp_q.delete();
        @(negedge clk1);
        check16("flush_valid", 16'(out_valid), 16'h0);
        check16("flush_nws",   16'(nws_drv),   16'h0);
        rd(A_STATUS, 16'h0001, "flush_status");
        pop_n(4);
        push_word(16'h1234);
        pop_n(1);
        rd(A_STATUS, 16'h0001, "post_flush");

        // Reset mid-stall with a concurrent write and pop request
        for (int i = 0; i < 16; i++) push_word(16'h0200 + 16'(i));
        wr(A_DATA, 16'h5A5A);
        rd(A_STATUS, 16'h100A, "rst_stall_pre");
        tick;
        reset = 1'b1; out_ready = 1'b1;
        niodev = 1'b0; nio = 1'b0; nw = 1'b0; ab_lo = A_DATA; db_in = 16'h5555;
        tick;
        reset = 1'b0; out_ready = 1'b0;
        bus_idle;
        exp_q.delete();
        @(negedge clk1);
        check16("rst2_valid", 16'(out_valid), 16'h0);
        check16("rst2_nws",   16'(nws_drv),   16'h0);
        check16("rst2_irq",   16'(irq_drv),   16'h0);
        rd(A_STATUS, 16'h0001, "rst2_status");
        push_word(16'h7777);
        pop_n(1);
        rd(A_STATUS, 16'h0001, "final_status");
        check16("queue_empty", 16'(exp_q.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
